shift_reg_univ: RTL

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

---
 rtl/shift_reg_univ.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shift_reg_univ.sv
// Universal shift register: shift/rotate/load/hold with a counted multi-step run mode.
// Define SHIFT_REG_UNIV_ARITH_EN to turn MODO=11 into a runnable arithmetic right shift.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic [CNT_W-1:0] CNT,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] M_SHIFT = 2'b00;
    localparam logic [1:0] M_ROT   = 2'b01;
    localparam logic [1:0] M_LOAD  = 2'b10;
    localparam logic [1:0] M_HOLD  = 2'b11;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             sout_reg, sout_next;
    logic             done_reg, done_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       mode_reg, mode_next;
    logic             dir_reg, dir_next;

    logic [WIDTH-1:0] up_q, dn_q;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;
    logic [1:0]       op_mode;
    logic             op_dir;
    logic             runnable;

    // up_q/dn_q: contents moved one place toward MSB/LSB with the vacated bit cleared
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            if (gi == 0) begin : g_lsb
                assign up_q[gi] = 1'b0;
                assign dn_q[gi] = q_reg[gi+1];
            end else if (gi == WIDTH-1) begin : g_msb
                assign up_q[gi] = q_reg[gi-1];
                assign dn_q[gi] = 1'b0;
            end else begin : g_mid
                assign up_q[gi] = q_reg[gi-1];
                assign dn_q[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    // During a run the latched mode/direction drive the datapath, otherwise the live inputs
    assign op_mode = (state_reg == RUN) ? mode_reg : MODO;
    assign op_dir  = (state_reg == RUN) ? dir_reg  : DIR;

    always_comb begin
        step_q    = q_reg;
        step_sout = sout_reg;
        unique case (op_mode)
            M_SHIFT, M_ROT: begin
                if (op_dir) begin
                    step_q    = dn_q | {((op_mode == M_ROT) ? q_reg[0] : S_IN), {(WIDTH-1){1'b0}}};
                    step_sout = q_reg[0];
                end else begin
                    step_q    = up_q | WIDTH'((op_mode == M_ROT) ? q_reg[WIDTH-1] : S_IN);
                    step_sout = q_reg[WIDTH-1];
                end
            end
            M_LOAD: step_q = D;
`ifdef SHIFT_REG_UNIV_ARITH_EN
            M_HOLD: begin
                step_q    = dn_q | {q_reg[WIDTH-1], {(WIDTH-1){1'b0}}};
                step_sout = q_reg[0];
            end
`else
            M_HOLD: ;
`endif
            default: ;
        endcase
    end

`ifdef SHIFT_REG_UNIV_ARITH_EN
    assign runnable = (MODO == M_SHIFT) || (MODO == M_ROT) || (MODO == M_HOLD);
`else
    assign runnable = (MODO == M_SHIFT) || (MODO == M_ROT);
`endif

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        sout_next  = sout_reg;
        done_next  = 1'b0;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        dir_next   = dir_reg;
        if (ENB) begin
            unique case (state_reg)
                IDLE: begin
                    if (START && runnable) begin
                        mode_next = MODO;
                        dir_next  = DIR;
                        cnt_next  = CNT;
                        if (CNT != '0) state_next = RUN;
                        else           done_next  = 1'b1;
                    end else begin
                        q_next    = step_q;
                        sout_next = step_sout;
                    end
                end
                RUN: begin
                    q_next    = step_q;
                    sout_next = step_sout;
                    cnt_next  = cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            sout_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
            mode_reg  <= M_SHIFT;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            sout_reg  <= sout_next;
            done_reg  <= done_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            dir_reg   <= dir_next;
        end
    end

    assign Q     = q_reg;
    assign S_OUT = sout_reg;
    assign BUSY  = (state_reg == RUN);
    assign DONE  = done_reg;
endmodule
